// File: rtl/or1200_operandmux_nway.sv
// -----------------------------------------------------------------------------
// or1200_operandmux_nway
//
// N-lane operand selection and ID/EX operand register for the multi-issue
// OR1200 core. For each lane, operand A comes from that lane's register file
// port A, or from the EX or WB forwarding result of any lane. Operand B uses
// the same sources and can also take the lane's sign-extended immediate. The
// selected values go into the EX-stage operand registers. Those registers hold
// steady while the pipeline is frozen.
//
// Parameters
//   LANES  number of issue lanes (1..8)
//   DW     datapath width
//   LIW    lane-index width, max(1, clog2(LANES)) (derived)
//   SW     per-lane select width, 2 + LIW (derived)
//
// Ports (lane i of every bus sits at [i*DW +: DW], or [i*SW +: SW] for selects)
//   clk        core clock, all state on rising edge
//   rst        asynchronous reset, active low
//   id_freeze  ID stage frozen
//   ex_freeze  EX stage frozen
//   rf_dataa   register file port A data, per lane
//   rf_datab   register file port B data, per lane
//   simm       sign-extended immediate, per lane
//   ex_forw    EX-stage result, per lane
//   wb_forw    WB-stage result, per lane
//   sel_a      operand A select {type, source lane}, per lane
//   sel_b      operand B select {type, source lane}, per lane
//   operand_a  registered EX operand A, per lane
//   operand_b  registered EX operand B, per lane
//   muxed_b    combinational operand B mux output (store data path), per lane
// -----------------------------------------------------------------------------
module or1200_operandmux_nway #(
    parameter  int LANES = 2,
    parameter  int DW    = 32,
    localparam int LIW   = (LANES > 1) ? $clog2(LANES) : 1,
    localparam int SW    = 2 + LIW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_freeze,
    input  logic                ex_freeze,
    input  logic [LANES*DW-1:0] rf_dataa,
    input  logic [LANES*DW-1:0] rf_datab,
    input  logic [LANES*DW-1:0] simm,
    input  logic [LANES*DW-1:0] ex_forw,
    input  logic [LANES*DW-1:0] wb_forw,
    input  logic [LANES*SW-1:0] sel_a,
    input  logic [LANES*SW-1:0] sel_b,
    output logic [LANES*DW-1:0] operand_a,
    output logic [LANES*DW-1:0] operand_b,
    output logic [LANES*DW-1:0] muxed_b
);

    // Select type encoding (same as OR1200_SEL_*)
    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_IMM = 2'd1;
    localparam logic [1:0] SEL_EX  = 2'd2;
    localparam logic [1:0] SEL_WB  = 2'd3;

    // Pick lane k out of a forwarding bus. If k names a lane that does not
    // exist, no entry matches and the caller's fallback (own-lane RF) is used.
    function automatic logic [DW-1:0] pick_lane(
        input logic [LANES*DW-1:0] bus,
        input logic [LIW-1:0]      k,
        input logic [DW-1:0]       fallback
    );
        logic [DW-1:0] r;
        r = fallback;
        for (int j = 0; j < LANES; j++) begin
            if (k == LIW'(j)) r = bus[j*DW +: DW];
        end
        return r;
    endfunction

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [1:0]     typ_a, typ_b;
        logic [LIW-1:0] k_a, k_b;
        logic [DW-1:0]  rf_a, rf_b, imm;
        logic [DW-1:0]  mux_a, mux_b;
        logic [DW-1:0]  reg_a, reg_b;
        logic           saved_a, saved_b;
        logic           load_a, load_b;

        assign typ_a = sel_a[g*SW+LIW +: 2];
        assign k_a   = sel_a[g*SW +: LIW];
        assign typ_b = sel_b[g*SW+LIW +: 2];
        assign k_b   = sel_b[g*SW +: LIW];
        assign rf_a  = rf_dataa[g*DW +: DW];
        assign rf_b  = rf_datab[g*DW +: DW];
        assign imm   = simm[g*DW +: DW];

        // Operand A has no immediate path: IMM falls through to RF.
        always_comb begin
            mux_a = rf_a;
            case (typ_a)
                SEL_EX:  mux_a = pick_lane(ex_forw, k_a, rf_a);
                SEL_WB:  mux_a = pick_lane(wb_forw, k_a, rf_a);
                default: mux_a = rf_a;
            endcase
        end

        always_comb begin
            mux_b = rf_b;
            case (typ_b)
                SEL_RF:  mux_b = rf_b;
                SEL_IMM: mux_b = imm;
                SEL_EX:  mux_b = pick_lane(ex_forw, k_b, rf_b);
                SEL_WB:  mux_b = pick_lane(wb_forw, k_b, rf_b);
                default: mux_b = rf_b;
            endcase
        end

        // The register loads only when EX is running and no captured value is
        // being protected. The saved flag follows id_freeze on every
        // non-EX-frozen edge. So a freeze captures on its first edge, and the
        // edge after id_freeze falls only clears the flag. Loading restarts
        // on the edge after that.
        assign load_a = !ex_freeze && !saved_a;
        assign load_b = !ex_freeze && !saved_b;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                reg_a   <= '0;
                saved_a <= 1'b0;
            end else begin
                if (!ex_freeze) saved_a <= id_freeze;
                if (load_a)     reg_a   <= mux_a;
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                reg_b   <= '0;
                saved_b <= 1'b0;
            end else begin
                if (!ex_freeze) saved_b <= id_freeze;
                if (load_b)     reg_b   <= mux_b;
            end
        end

        assign operand_a[g*DW +: DW] = reg_a;
        assign operand_b[g*DW +: DW] = reg_b;
        assign muxed_b[g*DW +: DW]   = mux_b;
    end

endmodule

// File: doc/or1200_operandmux_nway.md
# or1200_operandmux_nway

Parametrised N-lane operand mux and ID/EX operand register for the multi-issue OR1200 core. Per lane, it selects operand A from the register file or any lane's EX/WB forwarding result, and operand B from the same sources plus the sign-extended immediate. It registers the results into the EX stage and holds them stable across ID/EX freezes. It replaces per-lane hard-coded two-issue operand muxes, adding cross-lane forwarding and lane-count generality.

## Interface
- LANES, 2, issue lanes (1..8)
- DW, 32, datapath width
- LIW, derived, lane-index width = max(1, clog2(LANES)); not overridable
- SW, derived, per-lane select width = 2 + LIW
- clk  in  1  core clock, all state on rising edge
- rst  in  1  reset; asynchronous, active-low (rst=0 resets)
- id_freeze  in  1  ID stage frozen
- ex_freeze  in  1  EX stage frozen
- rf_dataa  in  LANES*DW  RF port A, lane i at [i*DW +: DW]
- rf_datab  in  LANES*DW  RF port B, lane i
- simm  in  LANES*DW  sign-extended immediate, lane i
- ex_forw  in  LANES*DW  EX-stage result of lane i
- wb_forw  in  LANES*DW  WB-stage result of lane i
- sel_a  in  LANES*SW  lane i select at [i*SW +: SW]
- sel_b  in  LANES*SW  lane i select
- operand_a  out  LANES*DW  registered EX operand A
- operand_b  out  LANES*DW  registered EX operand B
- muxed_b  out  LANES*DW  combinational B mux (store data path)

## Operation
- Select field layout: sel[SW-1:LIW] = type, sel[LIW-1:0] = source lane k.
- Type encoding matches `OR1200_SEL_*`:
  - 0 = RF (own lane's RF data; k ignored)
  - 1 = IMM (own lane's simm; k ignored)
  - 2 = EX_FORW (ex_forw of lane k)
  - 3 = WB_FORW (wb_forw of lane k)
- Operand A with type 1 selects rf_dataa (A has no immediate path).
- k >= LANES with type 2/3: falls back to own-lane RF data. This is not an error.
- muxed_a and muxed_b are pure combinational per lane; muxed_b is exported.
- Each lane has a saved_a and a saved_b flag. Each operand register updates independently but uses identical rules. Per operand, priority order:
  1. ex_freeze=1: hold register and saved flag.
  2. saved=0: register <= muxed; saved <= id_freeze.
  3. saved=1, id_freeze=1: hold register and flag (captured value is protected from forwarding sources moving on).
  4. saved=1, id_freeze=0: hold register; saved <= 0. Loading resumes on the following edge.
- All lanes share id_freeze and ex_freeze; there is no per-lane freeze.

## Timing
- Reset (rst=0, asynchronous): all operand_a, operand_b = 0; all saved flags = 0. Effect is immediate, independent of clk.
- Reset deassertion is synchronised externally; the first edge with rst=1 follows the normal rules.
- Reset asserted mid-freeze: flags clear; after release, the first unfrozen edge loads muxed.
- Latency: sel/data to muxed_b is 0 cycles (combinational). To operand_a/b is 1 edge, absent freeze.
- Freeze entry (id_freeze rises, ex_freeze=0): capture happens on the same edge that sets saved. Registers stay constant until two edges after id_freeze falls.
- ex_freeze=1 overrides everything, including a pending saved clear.
- Simultaneous id_freeze fall and ex_freeze rise: ex_freeze wins; the flag stays set until the first edge with ex_freeze=0 and id_freeze=0.
- No combinational path from operand outputs to inputs; no X on outputs after reset.

## Test plan
- **Reset:** drive rst=0 mid-cycle with operands nonzero -> operand_a/b = 0 immediately; muxed_b still tracks its inputs.
- **Basic select, LANES=2:** rf_dataa0=BA1A7EEE, ex_forw0=12345678, wb_forw1=0ABCDEF9.
  - lane0 sel_a={EX,0}, sel_b={WB,1} -> after 1 edge, operand_a0=12345678, operand_b0=0ABCDEF9.
  - lane1 sel_a={RF,x} -> operand_a1=rf_dataa1.
- **Immediate and out-of-range index:**
  - lane0 sel_b={IMM,x}, simm0=FFFFFFF0 -> operand_b0=FFFFFFF0.
  - sel_a={IMM,x} -> operand_a0=rf_dataa0.
  - LANES=3, sel_a={EX,3} -> rf_dataa.
- **ID freeze hold:** id_freeze=1 for 3 cycles with ex_forw0 changing each cycle -> operand_a0 keeps the value captured on the first frozen edge. It stays unchanged one edge after id_freeze falls and reloads on the next edge.
- **EX freeze priority:** ex_freeze=1 for 2 cycles while sel and data change -> all operands and flags hold. Dropping id_freeze while ex_freeze=1 does not clear saved.
- **Lane independence, LANES=4:** each lane selects wb_forw of lane (i+1)%4, with distinct values -> each operand_a matches its source lane exactly; no cross-lane bleed.
